// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU command sequencer and its compute core.
//   ALU_W   - default operand/result width
//   OP_*    - cmd_op encodings
//   state_t - sequencer FSM state encoding
package alu_pkg;

    localparam int ALU_W = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_SHL = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational compute for the command sequencer.
//   a, b  - operands (W bits)
//   op    - operation select (OP_ADD / OP_SUB / OP_XOR / OP_SHL)
//   y     - result modulo 2^W
//   cout  - carry out (add), not-borrow (sub), 0 (xor), shifted-out MSB (shl)
import alu_pkg::*;

module alu_core #(
    parameter int W = ALU_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   op,
    output logic [W-1:0] y,
    output logic         cout
);

    always_comb begin
        y    = '0;
        cout = 1'b0;
        case (op)
            OP_ADD: {cout, y} = {1'b0, a} + {1'b0, b};
            // Two's complement subtract; carry out of 1 means no borrow.
            OP_SUB: {cout, y} = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
            OP_XOR: y = a ^ b;
            OP_SHL: begin
                y    = {a[W-2:0], 1'b0};
                cout = a[W-1];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_cmd_seq.sv
// alu_cmd_seq: accepts one ALU command at a time, computes it in one cycle and
// holds the registered result until the consumer takes it. An accumulator keeps
// the last completed result so a command can chain on it (cmd_acc = 1).
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   cmd_valid / cmd_ready    - command handshake
//   cmd_op, cmd_a, cmd_b     - operation and operands
//   cmd_acc                  - use accumulator instead of cmd_a as operand A
//   res_valid / res_ready    - result handshake
//   res_data                 - registered result
//   res_cout, res_zero       - registered flags, only when ALU_CMD_SEQ_FLAGS_EN
//                              is defined
//
// Configuration macro: ALU_CMD_SEQ_FLAGS_EN (default undefined: no flag ports).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | cmd_ready=1, waiting for cmd_valid; operands latched on accept
// EXEC  | core computes from latched operands; result/acc loaded at end
// DONE  | res_valid=1, result held until res_ready
import alu_pkg::*;

module alu_cmd_seq #(
    parameter int W = ALU_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    input  logic         cmd_acc,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data
`ifdef ALU_CMD_SEQ_FLAGS_EN
    ,
    output logic         res_cout,
    output logic         res_zero
`endif
);

    state_t       state_q, state_d;
    logic [1:0]   op_q, op_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [W-1:0] acc_q, acc_d;
    logic [W-1:0] res_data_q, res_data_d;
    logic         res_valid_q, res_valid_d;
    logic         cmd_ready_q, cmd_ready_d;
`ifdef ALU_CMD_SEQ_FLAGS_EN
    logic         res_cout_q, res_cout_d;
    logic         res_zero_q, res_zero_d;
`endif

    logic [W-1:0] core_y;
    logic         core_cout;

    alu_core #(.W(W)) u_core (
        .a    (a_q),
        .b    (b_q),
        .op   (op_q),
        .y    (core_y),
        .cout (core_cout)
    );

`ifndef ALU_CMD_SEQ_FLAGS_EN
    // Carry is only consumed when flags are built in.
    logic core_cout_unused;
    assign core_cout_unused = core_cout;
`endif

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        cmd_ready_d = cmd_ready_q;
`ifdef ALU_CMD_SEQ_FLAGS_EN
        res_cout_d  = res_cout_q;
        res_zero_d  = res_zero_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d        = cmd_op;
                    a_d         = cmd_acc ? acc_q : cmd_a;
                    b_d         = cmd_b;
                    cmd_ready_d = 1'b0;
                    state_d     = EXEC;
                end
            end
            EXEC: begin
                res_data_d  = core_y;
                acc_d       = core_y;
`ifdef ALU_CMD_SEQ_FLAGS_EN
                res_cout_d  = core_cout;
                res_zero_d  = (core_y == '0);
`endif
                res_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                res_valid_d = 1'b0;
                cmd_ready_d = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
`ifdef ALU_CMD_SEQ_FLAGS_EN
            res_cout_q  <= 1'b0;
            res_zero_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            cmd_ready_q <= cmd_ready_d;
`ifdef ALU_CMD_SEQ_FLAGS_EN
            res_cout_q  <= res_cout_d;
            res_zero_q  <= res_zero_d;
`endif
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
`ifdef ALU_CMD_SEQ_FLAGS_EN
    assign res_cout  = res_cout_q;
    assign res_zero  = res_zero_q;
`endif

endmodule

// File: tb/tb_alu_cmd_seq.sv
// tb_alu_cmd_seq: directed scoreboard bench for alu_cmd_seq. Expected results
// are queued when a command is issued; a monitor pops and compares whenever a
// result handshake is about to complete. Flag checks only when
// ALU_CMD_SEQ_FLAGS_EN is defined.
module tb_alu_cmd_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       cmd_acc;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
`ifdef ALU_CMD_SEQ_FLAGS_EN
    logic       res_cout;
    logic       res_zero;
`endif

    alu_cmd_seq #(.W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_acc   (cmd_acc),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data)
`ifdef ALU_CMD_SEQ_FLAGS_EN
        ,
        .res_cout  (res_cout),
        .res_zero  (res_zero)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       c;
        logic       z;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: sample mid-low-phase, after inputs driven at negedge settle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("res_data", int'(res_data), int'(e.d));
`ifdef ALU_CMD_SEQ_FLAGS_EN
                    check("res_cout", int'(res_cout), int'(e.c));
                    check("res_zero", int'(res_zero), int'(e.z));
`endif
                end
            end
        end
    end

    // Issue one command, check acceptance and fixed one-cycle latency to res_valid.
    task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic acc, input logic [7:0] d, input logic c, input logic z);
        int t;
        exp_t e;
        e.d = d;
        e.c = c;
        e.z = z;
        exp_q.push_back(e);
        @(negedge clk);
        t = 0;
        while (!cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t == 50) check("cmd_ready_timeout", 0, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_acc   = acc;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("exec_cmd_ready", int'(cmd_ready), 0);
        check("exec_res_valid", int'(res_valid), 0);
        @(posedge clk);
        #1;
        check("latency_res_valid", int'(res_valid), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_a     = 8'h11;
        cmd_b     = 8'h22;
        cmd_acc   = 1'b0;
        res_ready = 1'b1;

        // Reset with a command offered: it must not be taken.
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_cmd_ready", int'(cmd_ready), 1);
            check("rst_res_valid", int'(res_valid), 0);
        end
        check("rst_res_data", int'(res_data), 0);
`ifdef ALU_CMD_SEQ_FLAGS_EN
        check("rst_res_cout", int'(res_cout), 0);
        check("rst_res_zero", int'(res_zero), 0);
`endif
        @(negedge clk);
        rst       = 1'b0;
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        check("idle_cmd_ready", int'(cmd_ready), 1);

        // Arithmetic vectors.
        send(2'b00, 8'hF0, 8'h20, 1'b0, 8'h10, 1'b1, 1'b0);
        send(2'b01, 8'h05, 8'h05, 1'b0, 8'h00, 1'b1, 1'b1);
        send(2'b01, 8'h03, 8'h05, 1'b0, 8'hFE, 1'b0, 1'b0);
        send(2'b00, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1);
        send(2'b11, 8'h81, 8'h00, 1'b0, 8'h02, 1'b1, 1'b0);
        send(2'b10, 8'hAA, 8'hAA, 1'b0, 8'h00, 1'b0, 1'b1);

        // Accumulate chain; cmd_a deliberately junk when acc is used.
        send(2'b00, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
        send(2'b11, 8'h77, 8'h00, 1'b1, 8'h04, 1'b0, 1'b0);
        send(2'b10, 8'h33, 8'hFF, 1'b1, 8'hFB, 1'b0, 1'b0);
        // Handshake completes at N+2: IDLE again right after.
        @(posedge clk);
        #1;
        check("n2_cmd_ready", int'(cmd_ready), 1);
        check("n2_res_valid", int'(res_valid), 0);

        // Consumer backpressure with a competing command offered.
        res_ready = 1'b0;
        send(2'b00, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_a     = 8'hFF;
        cmd_b     = 8'h00;
        cmd_acc   = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("bp_res_valid", int'(res_valid), 1);
            check("bp_res_data", int'(res_data), 8'h46);
            check("bp_cmd_ready", int'(cmd_ready), 0);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", int'(res_valid), 0);
        check("bp_release_ready", int'(cmd_ready), 1);

        // Reset while in EXEC: command discarded, accumulator cleared.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_a     = 8'h10;
        cmd_b     = 8'h10;
        cmd_acc   = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("rexec_accepted", int'(cmd_ready), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rexec_res_valid", int'(res_valid), 0);
        check("rexec_cmd_ready", int'(cmd_ready), 1);
        check("rexec_res_data", int'(res_data), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("post_rst_no_valid", int'(res_valid), 0);
        end
        // Accumulator must be zero: 0 + 7.
        send(2'b00, 8'h55, 8'h07, 1'b1, 8'h07, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
